// File: rtl/adder_result_buffer_pkg.sv
// Shared width defaults and the result entry layout so the 4-bit adder and
// everything that consumes its results agree on how a result is packed.
package adder_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_SUM_W   = 4;
  localparam int DEF_TOTAL_W = 8;
  localparam int DEF_OVC_W   = 4;

  // One buffered adder result: overflow flag above the sum bits.
  typedef struct packed {
    logic                 ov;
    logic [DEF_SUM_W-1:0] sum;
  } entry_t;

endpackage

// File: rtl/adder_result_buffer_if.sv
// Bundle of the adder-result input side, the valid/ready drain side and the
// status counters of the result buffer.
interface adder_result_buffer_if
  import adder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int TOTAL_W = DEF_TOTAL_W,
  parameter int OVC_W   = DEF_OVC_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               In_Valid;
  logic [SUM_W-1:0]   Sum;
  logic               Overflow;
  logic               In_Ready;
  logic [SUM_W:0]     Out_Data;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [CNT_W-1:0]   Count;
  logic [TOTAL_W-1:0] Total;
  logic [OVC_W-1:0]   Ov_Count;

  // Producer/consumer side: drives adder results and drain requests.
  modport master (
    output In_Valid, Sum, Overflow, Out_Ready,
    input  In_Ready, Out_Data, Out_Valid, Count, Total, Ov_Count
  );

  // Buffer side.
  modport slave (
    input  In_Valid, Sum, Overflow, Out_Ready,
    output In_Ready, Out_Data, Out_Valid, Count, Total, Ov_Count
  );

endinterface

// File: rtl/adder_result_buffer_core.sv
// Circular-buffer FIFO holding adder results. Occupancy is tracked with an
// explicit counter so full and empty are unambiguous without an extra
// pointer bit. There is no bypass path: a push is only accepted when the
// registered count says there is room.
module result_fifo_core
  import adder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_SUM_W + 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [W-1:0]     wdata,
  input  logic             pop_req,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             push
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = push_req && in_ready;
  assign pop       = pop_req && out_valid;

  // Empty buffer presents zero so stale storage never leaks out.
  assign rdata = out_valid ? mem[rd_ptr] : '0;

  // Storage is written on every accepted push and deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); reset discards entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_buffer.sv
// Result buffer sitting behind the 4-bit adder: queues {Overflow, Sum}
// results for a slower consumer and keeps a wrap-around running total of
// accepted sums plus a saturating count of overflowed results.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int TOTAL_W = DEF_TOTAL_W,
  parameter int OVC_W   = DEF_OVC_W
) (
  input logic                  Clk,
  input logic                  Reset,
  adder_result_buffer_if.slave bus
);

  logic               push;
  logic [TOTAL_W-1:0] total;
  logic [OVC_W-1:0]   ov_count;

  result_fifo_core #(
    .DEPTH (DEPTH),
    .W     (SUM_W + 1)
  ) u_core (
    .clk       (Clk),
    .rst       (Reset),
    .push_req  (bus.In_Valid),
    .wdata     ({bus.Overflow, bus.Sum}),
    .pop_req   (bus.Out_Ready),
    .in_ready  (bus.In_Ready),
    .out_valid (bus.Out_Valid),
    .rdata     (bus.Out_Data),
    .count     (bus.Count),
    .push      (push)
  );

  assign bus.Total    = total;
  assign bus.Ov_Count = ov_count;

  // Accumulators follow accepted pushes only; dropped results are not counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      total    <= '0;
      ov_count <= '0;
    end else if (push) begin
      total <= total + TOTAL_W'(bus.Sum);
      if (bus.Overflow && (ov_count != '1)) begin
        ov_count <= ov_count + OVC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: directed plan steps followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_adder_result_buffer;
  import adder_pkg::*;

  localparam int DEPTH = 4;

  logic Clk;
  logic Reset;

  adder_result_buffer_if #(.DEPTH(DEPTH)) bus ();

  adder_result_buffer #(
    .DEPTH   (DEPTH),
    .SUM_W   (4),
    .TOTAL_W (8),
    .OVC_W   (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: FIFO contents, running total and overflow count.
  entry_t modelQ[$];
  int     modelTotal;
  int     modelOvc;
  int     drops;
  int     checks;
  int     errors;

  // One comparison point.
  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the model's view of the buffer.
  task automatic checkOutput(input string tag);
    int n;
    n = modelQ.size();
    checkVal({tag, "_count"},    32'(bus.Count),     n);
    checkVal({tag, "_outvalid"}, 32'(bus.Out_Valid), (n != 0) ? 1 : 0);
    checkVal({tag, "_inready"},  32'(bus.In_Ready),  (n != DEPTH) ? 1 : 0);
    checkVal({tag, "_outdata"},  32'(bus.Out_Data),  (n != 0) ? 32'(modelQ[0]) : 0);
    checkVal({tag, "_total"},    32'(bus.Total),     modelTotal);
    checkVal({tag, "_ovcount"},  32'(bus.Ov_Count),  modelOvc);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic rst, input logic iv,
                               input logic [3:0] s, input logic ov,
                               input logic ordy, input string tag);
    bit doPush;
    bit doPop;
    entry_t e;
    Reset         = rst;
    bus.In_Valid  = iv;
    bus.Sum       = s;
    bus.Overflow  = ov;
    bus.Out_Ready = ordy;
    doPush = iv && (modelQ.size() < DEPTH);
    doPop  = ordy && (modelQ.size() > 0);
    if (iv && !doPush && !rst) drops++;
    @(posedge Clk);
    #1;
    if (rst) begin
      modelQ.delete();
      modelTotal = 0;
      modelOvc   = 0;
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (doPush) begin
        e.ov  = ov;
        e.sum = s;
        modelQ.push_back(e);
        modelTotal = (modelTotal + int'(s)) % 256;
        if (ov && modelOvc < 15) modelOvc++;
      end
    end
    checkOutput(tag);
  endtask

  int fillVals[4]  = '{4, 7, 9, 15};
  logic [3:0] rs;
  logic riv, rov, rrdy, rrst;

  initial begin
    checks = 0;
    errors = 0;
    drops  = 0;
    modelTotal = 0;
    modelOvc   = 0;
    Reset = 1'b1;
    bus.In_Valid  = 1'b0;
    bus.Sum       = '0;
    bus.Overflow  = 1'b0;
    bus.Out_Ready = 1'b0;

    // Reset for two cycles, then idle.
    applyStimulus(1, 0, 0, 0, 0, "reset");
    applyStimulus(1, 0, 0, 0, 0, "reset");
    applyStimulus(0, 0, 0, 0, 0, "idle");
    checkVal("rst_outvalid", 32'(bus.Out_Valid), 0);
    checkVal("rst_outdata",  32'(bus.Out_Data), 0);
    checkVal("rst_inready",  32'(bus.In_Ready), 1);
    checkVal("rst_total",    32'(bus.Total), 0);

    // Single push then pop.
    applyStimulus(0, 1, 13, 0, 0, "single_push");
    checkVal("single_outdata", 32'(bus.Out_Data), 32'h0D);
    checkVal("single_total",   32'(bus.Total), 13);
    applyStimulus(0, 0, 0, 0, 1, "single_pop");
    checkVal("single_popcount", 32'(bus.Count), 0);

    // Fill, drop a fifth value, drain in order.
    applyStimulus(1, 0, 0, 0, 0, "fill_reset");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4'(fillVals[i]), 0, 0, "fill");
    checkVal("fill_inready", 32'(bus.In_Ready), 0);
    checkVal("fill_count",   32'(bus.Count), 4);
    checkVal("fill_total",   32'(bus.Total), 35);
    applyStimulus(0, 1, 2, 0, 0, "fill_drop");
    checkVal("fill_drop_total", 32'(bus.Total), 35);
    for (int i = 0; i < 4; i++) begin
      checkVal("drain_order", 32'(bus.Out_Data), fillVals[i]);
      applyStimulus(0, 0, 0, 0, 1, "drain");
    end

    // Two entries, then simultaneous push/pop across the pointer wrap.
    applyStimulus(0, 1, 1, 0, 0, "wrap_pre");
    applyStimulus(0, 1, 2, 0, 0, "wrap_pre");
    for (int i = 0; i < 6; i++) begin
      checkVal("wrap_order", 32'(bus.Out_Data), 1 + i);
      applyStimulus(0, 1, 4'(3 + i), 0, 1, "wrap");
      checkVal("wrap_count", 32'(bus.Count), 2);
    end
    checkVal("wrap_tail0", 32'(bus.Out_Data), 7);
    applyStimulus(0, 0, 0, 0, 1, "wrap_drain");
    checkVal("wrap_tail1", 32'(bus.Out_Data), 8);
    applyStimulus(0, 0, 0, 0, 1, "wrap_drain");

    // Total wrap-around and overflow counter saturation.
    applyStimulus(1, 0, 0, 0, 0, "sat_reset");
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 15, 1, 1, "sat");
    checkVal("sat_total", 32'(bus.Total), 44);
    checkVal("sat_ovc",   32'(bus.Ov_Count), 15);
    applyStimulus(0, 0, 0, 0, 1, "sat_drain");

    // Reset in the same cycle as a push with three entries held.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'(i + 1), 0, 0, "mid_fill");
    checkVal("mid_count3", 32'(bus.Count), 3);
    applyStimulus(1, 1, 11, 1, 0, "mid_reset");
    checkVal("mid_count",    32'(bus.Count), 0);
    checkVal("mid_outvalid", 32'(bus.Out_Valid), 0);
    checkVal("mid_total",    32'(bus.Total), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, "mid_idle");
      checkVal("mid_no_ghost", 32'(bus.Out_Data), 0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rrst = ($urandom_range(0, 63) == 0);
      riv  = ($urandom_range(0, 3) != 0);
      rs   = 4'($urandom_range(0, 15));
      rov  = 1'($urandom_range(0, 1));
      rrdy = ($urandom_range(0, 2) != 0);
      applyStimulus(rrst, riv, rs, rov, rrdy, "rand");
    end

    $display("[TB] dropped inputs observed: %0d", drops);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
